// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: state encodings, bus-idle control
// word and the common enable/zero constants.
package bus_arbiter_pkg;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [3:0]  SelAll      = 4'b1111;
  localparam logic [3:0]  SelNone     = 4'b0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    DONE_D = 3'd3,
    DONE_I = 3'd4,
    DRAIN  = 3'd5
  } arb_state_e;

  typedef struct packed {
    logic cyc;
    logic stb;
    logic we;
  } bus_ctl_t;

  localparam bus_ctl_t BusIdle = '{cyc: 1'b0, stb: 1'b0, we: 1'b0};

endpackage

// File: rtl/bus_arbiter.sv
// Two-port (data, fetch) to single Wishbone-style master arbiter.
// Data port has priority; a flush abandons the result but lets the bus cycle finish.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          if_ce_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  output logic          if_stall_o,
  input  logic          mem_ce_i,
  input  logic          mem_we_i,
  input  logic [3:0]    mem_sel_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_data_i,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_stall_o,
  output logic          bus_cyc_o,
  output logic          bus_stb_o,
  output logic          bus_we_o,
  output logic [3:0]    bus_sel_o,
  output logic [AW-1:0] bus_adr_o,
  output logic [DW-1:0] bus_dat_o,
  input  logic [DW-1:0] bus_dat_i,
  input  logic          bus_ack_i
);

  arb_state_e state;
  bus_ctl_t   ctl;

  assign bus_cyc_o = ctl.cyc;
  assign bus_stb_o = ctl.stb;
  assign bus_we_o  = ctl.we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctl        <= BusIdle;
      bus_sel_o  <= SelNone;
      bus_adr_o  <= '0;
      bus_dat_o  <= '0;
      if_data_o  <= '0;
      mem_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush) begin
            if (mem_ce_i == ChipEnable) begin
              state     <= BUSY_D;
              ctl       <= '{cyc: 1'b1, stb: 1'b1, we: mem_we_i};
              bus_sel_o <= mem_sel_i;
              bus_adr_o <= mem_addr_i;
              bus_dat_o <= mem_data_i;
            end else if (if_ce_i == ChipEnable) begin
              state     <= BUSY_I;
              ctl       <= '{cyc: 1'b1, stb: 1'b1, we: 1'b0};
              bus_sel_o <= SelAll;
              bus_adr_o <= if_addr_i;
              bus_dat_o <= '0;
            end
          end
        end
        BUSY_D, BUSY_I: begin
          if (bus_ack_i) begin
            ctl <= BusIdle;
            if (flush) begin
              state <= IDLE;
            end else if (state == BUSY_I) begin
              state     <= DONE_I;
              if_data_o <= bus_dat_i;
            end else begin
              state <= DONE_D;
              if (bus_we_o != WriteEnable) mem_data_o <= bus_dat_i;
            end
          end else if (flush) begin
            // Slave still owes an ack; keep the cycle open and drop the data later.
            state <= DRAIN;
          end
        end
        DONE_D, DONE_I: state <= IDLE;
        DRAIN: begin
          if (bus_ack_i) begin
            state <= IDLE;
            ctl   <= BusIdle;
          end
        end
        default: begin
          state <= IDLE;
          ctl   <= BusIdle;
        end
      endcase
    end
  end

  assign mem_stall_o = ~rst & mem_ce_i & ~flush & (state != DONE_D) & (state != DRAIN);
  assign if_stall_o  = ~rst & if_ce_i  & ~flush & (state != DONE_I) & (state != DRAIN);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: table of transactions plus hand-written
// flush and reset sequences; bus cycles are checked against a queue of expectations.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stall_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_stall_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;

  bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stall_o(if_stall_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_stall_o(mem_stall_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_exp_t;

  typedef struct {
    logic        mem_ce;
    logic        if_ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] maddr;
    logic [31:0] iaddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    logic [31:0] exp_mem;
    logic [31:0] exp_if;
    int          exp_ms;
    int          exp_is;
    int          exp_cyc;
  } vec_t;

  bus_exp_t bus_q[$];
  bus_exp_t cur;
  logic     cyc_q;
  int       total = 0;
  int       bad = 0;
  vec_t     tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bus-side scoreboard: new cycle pops an expectation, open cycle must hold still.
  task automatic monitor();
    if (bus_cyc_o && !cyc_q) begin
      if (bus_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_bus_cycle: got adr %h want no cycle", bus_adr_o);
      end else begin
        cur = bus_q.pop_front();
        chk("bus_stb", {31'b0, bus_stb_o}, 32'd1);
        chk("bus_adr", bus_adr_o, cur.adr);
        chk("bus_we", {31'b0, bus_we_o}, {31'b0, cur.we});
        chk("bus_sel", {28'b0, bus_sel_o}, {28'b0, cur.sel});
        if (cur.we) chk("bus_dat", bus_dat_o, cur.dat);
      end
    end else if (bus_cyc_o && cyc_q) begin
      chk("hold_adr", bus_adr_o, cur.adr);
      chk("hold_sel", {28'b0, bus_sel_o}, {28'b0, cur.sel});
      chk("hold_we", {31'b0, bus_we_o}, {31'b0, cur.we});
      if (cur.we) chk("hold_dat", bus_dat_o, cur.dat);
    end
    cyc_q = bus_cyc_o;
  endtask

  task automatic half();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat);
    bus_exp_t e;
    e.we = we; e.sel = sel; e.adr = adr; e.dat = dat;
    bus_q.push_back(e);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc_n = 0;
    int ms = 0;
    int is = 0;
    int busy = 0;
    bit md, id;
    md = !v.mem_ce;
    id = !v.if_ce;
    if (v.mem_ce) push_exp(v.we, v.sel, v.maddr, v.wdata);
    if (v.if_ce)  push_exp(1'b0, 4'b1111, v.iaddr, 32'h0);
    mem_ce_i = v.mem_ce; mem_we_i = v.we; mem_sel_i = v.sel;
    mem_addr_i = v.maddr; mem_data_i = v.wdata;
    if_ce_i = v.if_ce; if_addr_i = v.iaddr;
    while (!(md && id) && cyc_n < 50) begin
      if (bus_cyc_o && bus_stb_o) begin
        busy++;
        bus_ack_i = (busy == v.ack_dly);
        bus_dat_i = v.rdata;
      end else begin
        busy = 0;
        bus_ack_i = 1'b0;
        bus_dat_i = 32'h0;
      end
      half();
      cyc_n++;
      if (mem_ce_i) begin
        if (mem_stall_o) ms++;
        else begin
          md = 1'b1;
          chk($sformatf("v%0d_mem_data", idx), mem_data_o, v.exp_mem);
          chk($sformatf("v%0d_done_cyc", idx), {31'b0, bus_cyc_o}, 32'd0);
        end
      end
      if (if_ce_i) begin
        if (if_stall_o) is++;
        else begin
          id = 1'b1;
          chk($sformatf("v%0d_if_data", idx), if_data_o, v.exp_if);
          chk($sformatf("v%0d_done_cyc_i", idx), {31'b0, bus_cyc_o}, 32'd0);
        end
      end
      adv();
      if (md) mem_ce_i = 1'b0;
      if (id) if_ce_i = 1'b0;
    end
    bus_ack_i = 1'b0;
    if (!(md && id)) begin
      total++; bad++;
      $display("FAIL v%0d_timeout: got no completion want completion within 50 cycles", idx);
      mem_ce_i = 1'b0; if_ce_i = 1'b0;
    end else begin
      chk($sformatf("v%0d_cycles", idx), cyc_n, v.exp_cyc);
      if (v.mem_ce) chk($sformatf("v%0d_mem_stall_cycles", idx), ms, v.exp_ms);
      if (v.if_ce)  chk($sformatf("v%0d_if_stall_cycles", idx), is, v.exp_is);
    end
  endtask

  initial begin
    //           mem if we sel      maddr         iaddr         wdata         rdata        dly exp_mem       exp_if        ms is cyc
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h8000_0010, 32'h0, 32'h0, 32'hDEAD_BEEF, 1,
               32'hDEAD_BEEF, 32'h0, 2, 0, 3};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 4'b0011, 32'h8000_0020, 32'h0000_0040, 32'h1234_5678,
               32'h1357_9BDF, 1, 32'hDEAD_BEEF, 32'h1357_9BDF, 2, 5, 6};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 4'b1100, 32'h8000_0030, 32'h0, 32'hCAFE_F00D, 32'h9999_9999,
               5, 32'hDEAD_BEEF, 32'h1357_9BDF, 6, 0, 7};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1,
               32'hDEAD_BEEF, 32'h1111_1111, 0, 2, 3};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_0004, 32'h0, 32'h2222_2222, 1,
               32'hDEAD_BEEF, 32'h2222_2222, 0, 2, 3};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_0008, 32'h0, 32'h3333_3333, 1,
               32'hDEAD_BEEF, 32'h3333_3333, 0, 2, 3};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h8000_0040, 32'h0, 32'h0, 32'h0BAD_CAFE, 3,
               32'h0BAD_CAFE, 32'h3333_3333, 4, 0, 5};

    cyc_q = 1'b0;
    rst = 1'b1; flush = 1'b0;
    mem_ce_i = 1'b1; if_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b1111;
    mem_addr_i = 32'h1234; mem_data_i = 32'h5678; if_addr_i = 32'h9ABC;
    bus_dat_i = 32'hFFFF_FFFF; bus_ack_i = 1'b1;

    // Reset state, with requests and ack asserted to show they are ignored.
    repeat (2) @(posedge clk);
    half();
    chk("rst_cyc", {31'b0, bus_cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, bus_stb_o}, 32'd0);
    chk("rst_we", {31'b0, bus_we_o}, 32'd0);
    chk("rst_sel", {28'b0, bus_sel_o}, 32'd0);
    chk("rst_adr", bus_adr_o, 32'd0);
    chk("rst_dat", bus_dat_o, 32'd0);
    chk("rst_if_data", if_data_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_mem_stall", {31'b0, mem_stall_o}, 32'd0);
    chk("rst_if_stall", {31'b0, if_stall_o}, 32'd0);
    mem_ce_i = 1'b0; if_ce_i = 1'b0; bus_ack_i = 1'b0; bus_dat_i = 32'h0;
    rst = 1'b0;
    adv();

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Flush during fetch: cycle is drained until ack, data is dropped.
    push_exp(1'b0, 4'b1111, 32'h0000_0100, 32'h0);
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0100;
    half(); chk("fl_c0_if_stall", {31'b0, if_stall_o}, 32'd1); adv();
    half(); chk("fl_c1_cyc", {31'b0, bus_cyc_o}, 32'd1); adv();
    flush = 1'b1;
    half(); chk("fl_c2_if_stall", {31'b0, if_stall_o}, 32'd0); adv();
    flush = 1'b0; mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8000_0060;
    half();
    chk("fl_drain_cyc", {31'b0, bus_cyc_o}, 32'd1);
    chk("fl_drain_stb", {31'b0, bus_stb_o}, 32'd1);
    chk("fl_drain_mem_stall", {31'b0, mem_stall_o}, 32'd0);
    chk("fl_drain_if_stall", {31'b0, if_stall_o}, 32'd0);
    adv();
    mem_ce_i = 1'b0; if_ce_i = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'hAAAA_5555;
    half(); chk("fl_ack_cyc", {31'b0, bus_cyc_o}, 32'd1); adv();
    half();
    chk("fl_idle_cyc", {31'b0, bus_cyc_o}, 32'd0);
    chk("fl_if_data", if_data_o, 32'h3333_3333);
    adv();
    bus_ack_i = 1'b0;
    half();
    chk("fl_idle_ack_cyc", {31'b0, bus_cyc_o}, 32'd0);
    chk("fl_idle_ack_if_data", if_data_o, 32'h3333_3333);
    adv();

    // Flush together with ack on a load: back to idle, load data discarded.
    push_exp(1'b0, 4'b1111, 32'h8000_0050, 32'h0);
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h8000_0050;
    half(); adv();
    flush = 1'b1; bus_ack_i = 1'b1; bus_dat_i = 32'h5A5A_5A5A;
    half(); chk("fa_mem_stall", {31'b0, mem_stall_o}, 32'd0); adv();
    flush = 1'b0; bus_ack_i = 1'b0; mem_ce_i = 1'b0;
    half();
    chk("fa_cyc", {31'b0, bus_cyc_o}, 32'd0);
    chk("fa_mem_data", mem_data_o, 32'h0BAD_CAFE);
    adv();

    // Asynchronous reset in the middle of a store.
    push_exp(1'b1, 4'b1010, 32'h8000_0044, 32'h7766_5544);
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b1010;
    mem_addr_i = 32'h8000_0044; mem_data_i = 32'h7766_5544;
    half(); adv();
    half(); chk("ar_busy_cyc", {31'b0, bus_cyc_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_cyc", {31'b0, bus_cyc_o}, 32'd0);
    chk("ar_stb", {31'b0, bus_stb_o}, 32'd0);
    chk("ar_we", {31'b0, bus_we_o}, 32'd0);
    chk("ar_sel", {28'b0, bus_sel_o}, 32'd0);
    chk("ar_adr", bus_adr_o, 32'd0);
    chk("ar_dat", bus_dat_o, 32'd0);
    chk("ar_mem_data", mem_data_o, 32'd0);
    chk("ar_if_data", if_data_o, 32'd0);
    chk("ar_mem_stall", {31'b0, mem_stall_o}, 32'd0);
    mem_ce_i = 1'b0;
    adv();
    rst = 1'b0;
    cyc_q = 1'b0;
    half(); chk("ar_after_cyc", {31'b0, bus_cyc_o}, 32'd0);

    chk("queue_empty", bus_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
